// File: rtl/s27_lock.sv
// s27_lock: s27 benchmark core behind a sequential key lock.
//
// After every reset the block samples KEY_CYCLES 4-bit words on {G3,G2,G1,G0}.
// A fully correct sequence enters FUNC, where the s27 core runs unmodified.
// Any wrong word enters BAD, where the core still runs but G17 is XORed with
// the lsb of a free-running 8-bit LFSR. FUNC and BAD are left only by reset.
//
// Parameters:
//   KEY_CYCLES  number of key words (1..16)
//   KEY         key words, word i = KEY[4i+3:4i]
//   LFSR_SEED   corruption LFSR reset value (nonzero)
// Ports:
//   clk         clock, all state updates on posedge
//   reset       synchronous active-high reset
//   G0..G3      primary inputs (key words, then functional data)
//   G17         primary output, combinational from inputs and state
module s27_lock #(
    parameter int unsigned             KEY_CYCLES = 4,
    parameter logic [4*KEY_CYCLES-1:0] KEY        = 16'hA5C3,
    parameter logic [7:0]              LFSR_SEED  = 8'hB9
) (
    input  logic clk,
    input  logic reset,
    input  logic G0,
    input  logic G1,
    input  logic G2,
    input  logic G3,
    output logic G17
);

    localparam int unsigned KcntW = (KEY_CYCLES > 1) ? $clog2(KEY_CYCLES) : 1;

    localparam logic [1:0] StKey  = 2'd0;
    localparam logic [1:0] StFunc = 2'd1;
    localparam logic [1:0] StBad  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KcntW-1:0] kcnt_q, kcnt_d;
    logic             ok_q, ok_d;
    logic             g5_q, g5_d;
    logic             g6_q, g6_d;
    logic             g7_q, g7_d;
    logic [7:0]       lfsr_q, lfsr_d;

    logic [3:0] gin;
    logic [3:0] key_word;
    logic       match;
    logic       last_key;

    logic n2, n3, n4, n5, n6, n12, n17, n22;
    logic core_out;

    assign gin      = {G3, G2, G1, G0};
    assign key_word = KEY[4*int'(kcnt_q) +: 4];
    assign match    = (gin == key_word);
    assign last_key = (kcnt_q == KcntW'(KEY_CYCLES - 1));

    // Unmodified s27 combinational core.
    assign n2       = ~G0;
    assign n3       = ~(G1 | g7_q);
    assign n5       = ~(g6_q & n2);
    assign n6       = ~(n3 & G3);
    assign n4       = n5 & n6;
    assign n17      = ~(g5_q | n4);
    assign n12      = ~(n17 | n2);
    assign n22      = ~(G2 | n3);
    assign core_out = ~n17;

    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        ok_d    = ok_q;
        g5_d    = g5_q;
        g6_d    = g6_q;
        g7_d    = g7_q;
        lfsr_d  = lfsr_q;
        G17     = 1'b0;

        case (state_q)
            StKey: begin
                // Mismatch is sticky and never shortens the key phase.
                ok_d = ok_q & match;
                if (last_key) begin
                    state_d = (ok_q && match) ? StFunc : StBad;
                    kcnt_d  = '0;
                end else begin
                    kcnt_d = kcnt_q + 1'b1;
                end
                g5_d = 1'b0;
                g6_d = 1'b0;
                g7_d = 1'b0;
            end
            StFunc: begin
                g7_d = n22;
                g6_d = n17;
                g5_d = n12;
                G17  = core_out;
            end
            StBad: begin
                g7_d   = n22;
                g6_d   = n17;
                g5_d   = n12;
                G17    = core_out ^ lfsr_q[0];
                // Fibonacci taps 8,6,5,4: maximal length (255).
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
            default: begin
                // Unused encoding: fall back to the key phase.
                state_d = StKey;
                kcnt_d  = '0;
                ok_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StKey;
            kcnt_q  <= '0;
            ok_q    <= 1'b1;
            g5_q    <= 1'b0;
            g6_q    <= 1'b0;
            g7_q    <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            kcnt_q  <= kcnt_d;
            ok_q    <= ok_d;
            g5_q    <= g5_d;
            g6_q    <= g6_d;
            g7_q    <= g7_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule

// File: tb/tb_s27_lock.sv
// Directed bench for s27_lock: default 4-word key instance plus a 1-word instance.
module tb_s27_lock;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst1;
    logic [3:0] g;
    logic [3:0] h;
    logic       g17;
    logic       g17_1;

    int checks = 0;
    int errors = 0;

    // Golden unlocked s27 state and expected corruption LFSR.
    logic       m5, m6, m7;
    logic [7:0] ml;

    always #5 clk = ~clk;

    s27_lock dut (
        .clk  (clk),
        .reset(rst),
        .G0   (g[0]),
        .G1   (g[1]),
        .G2   (g[2]),
        .G3   (g[3]),
        .G17  (g17)
    );

    s27_lock #(
        .KEY_CYCLES(1),
        .KEY       (4'h7),
        .LFSR_SEED (8'hB9)
    ) dut1 (
        .clk  (clk),
        .reset(rst1),
        .G0   (h[0]),
        .G1   (h[1]),
        .G2   (h[2]),
        .G3   (h[3]),
        .G17  (g17_1)
    );

    // Returns {out, next G5, next G6, next G7}.
    function automatic logic [3:0] golden(input logic [3:0] x, input logic a5, input logic a6,
                                          input logic a7);
        logic n2, n3, n4, n5, n6, n12, n17, n22;
        n2  = ~x[0];
        n3  = ~(x[1] | a7);
        n5  = ~(a6 & n2);
        n6  = ~(n3 & x[3]);
        n4  = n5 & n6;
        n17 = ~(a5 | n4);
        n12 = ~(n17 | n2);
        n22 = ~(x[2] | n3);
        return {~n17, n12, n17, n22};
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        g   = 4'h0;
        tick();
        rst = 1'b0;
        m5  = 1'b0;
        m6  = 1'b0;
        m7  = 1'b0;
        ml  = 8'hB9;
    endtask

    task automatic key_word(input logic [3:0] w, input string tag);
        g = w;
        #1;
        chk(tag, g17, 1'b0);
        tick();
    endtask

    // One post-key cycle: check against golden (optionally corrupted), then advance.
    task automatic vec(input logic [3:0] x, input logic bad, input string tag);
        logic [3:0] r;
        g = x;
        #1;
        r = golden(x, m5, m6, m7);
        chk(tag, g17, r[3] ^ (bad & ml[0]));
        m5 = r[2];
        m6 = r[1];
        m7 = r[0];
        if (bad) ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
        tick();
    endtask

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        g    = 4'h0;
        h    = 4'h0;
        m5   = 1'b0;
        m6   = 1'b0;
        m7   = 1'b0;
        ml   = 8'hB9;
        tick();

        // Correct key, then golden comparison.
        do_reset();
        key_word(4'h3, "ok_key0");
        key_word(4'hC, "ok_key1");
        key_word(4'h5, "ok_key2");
        key_word(4'hA, "ok_key3");
        g = 4'h0;
        #1;
        chk("func_first", g17, 1'b1);
        vec(4'h0, 1'b0, "func_vec0");
        for (int i = 0; i < 200; i++) vec(4'($urandom_range(15)), 1'b0, "func_rand");

        // Wrong last word: corrupted stream from seed.
        do_reset();
        key_word(4'h3, "bad_last_key0");
        key_word(4'hC, "bad_last_key1");
        key_word(4'h5, "bad_last_key2");
        key_word(4'hB, "bad_last_key3");
        g = 4'h0;
        #1;
        chk("bad_first", g17, 1'b0);
        for (int i = 0; i < 30; i++) vec(4'((i * 5 + 3) & 15), 1'b1, "bad_stream");

        // Wrong first word: key cycles stay silent even on a word that BAD would expose.
        do_reset();
        key_word(4'h2, "bad_first_key0");
        key_word(4'hC, "bad_first_key1");
        key_word(4'h5, "bad_first_key2");
        key_word(4'hA, "bad_first_key3");
        g = 4'hC;
        #1;
        chk("bad_after_4", g17, 1'b1);

        // Reset mid-key restarts the sequence at word 0.
        do_reset();
        key_word(4'h3, "midkey_key0");
        key_word(4'hC, "midkey_key1");
        do_reset();
        key_word(4'h3, "midkey_re0");
        key_word(4'hC, "midkey_re1");
        key_word(4'h5, "midkey_re2");
        key_word(4'hA, "midkey_re3");
        g = 4'h0;
        #1;
        chk("midkey_func", g17, 1'b1);

        // Reset in BAD: correct key reaches FUNC, wrong key replays seed stream.
        do_reset();
        key_word(4'h3, "inbad_key0");
        key_word(4'hC, "inbad_key1");
        key_word(4'h5, "inbad_key2");
        key_word(4'h0, "inbad_key3");
        for (int i = 0; i < 10; i++) vec(4'((i * 3 + 1) & 15), 1'b1, "inbad_run");
        do_reset();
        key_word(4'h3, "rebad_key0");
        key_word(4'hC, "rebad_key1");
        key_word(4'h5, "rebad_key2");
        key_word(4'hA, "rebad_key3");
        g = 4'h0;
        #1;
        chk("rebad_func", g17, 1'b1);
        do_reset();
        key_word(4'h3, "reseed_key0");
        key_word(4'hC, "reseed_key1");
        key_word(4'h5, "reseed_key2");
        key_word(4'hB, "reseed_key3");
        for (int i = 0; i < 30; i++) vec(4'((i * 5 + 3) & 15), 1'b1, "reseed_stream");

        // KEY_CYCLES=1 instance.
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        h    = 4'h7;
        #1;
        chk("k1_key_ok", g17_1, 1'b0);
        tick();
        h = 4'h0;
        #1;
        chk("k1_func", g17_1, 1'b1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        h    = 4'h6;
        #1;
        chk("k1_key_bad", g17_1, 1'b0);
        tick();
        h = 4'h0;
        #1;
        chk("k1_bad", g17_1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
